// File: rtl/sseg_display_arbiter_if.sv
// Requester-side bundle for the seven-segment display arbiter: requests and
// frames in, grant/busy and the multiplexed an/seg pins out.
interface sseg_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] frame;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;
  logic [3:0]            an;
  logic [7:0]            seg;

  modport master (output req, frame, input gnt, busy, an, seg);
  modport slave  (input req, frame, output gnt, busy, an, seg);
endinterface

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner arbitration with a time-slot limit for a 4-digit
// multiplexed seven-segment display; scans the owner's live frame onto an/seg.
module sseg_display_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REFRESH_CYCLES = 65536,
  parameter int SLOT_CYCLES    = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  sseg_display_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST    = SW'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [RW-1:0]        refresh_q, refresh_d;
  logic [1:0]           scan_q, scan_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic [3:0]           an_q, an_d;
  logic [7:0]           seg_q, seg_d;

  logic [7:0]           frame_byte [NUM_REQ][4];
  logic [PW:0]          idle_pick, pre_pick;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    for (genvar gj = 0; gj < 4; gj++) begin : g_dig
      assign frame_byte[gi][gj] = bus.frame[32*gi + 8*gj +: 8];
    end
  end

  // First requester at base+first .. base+NUM_REQ-1 (circular); returns {hit, index}.
  function automatic logic [PW:0] pick(input logic [NUM_REQ-1:0] r,
                                       input logic [PW-1:0]      base,
                                       input int                 first);
    logic [PW:0] res;
    int          c;
    res = '0;
    for (int k = NUM_REQ - 1; k >= first; k--) begin
      c = int'(base) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (r[PW'(c)]) res = {1'b1, PW'(c)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
  endfunction

  assign idle_pick = pick(bus.req, rr_q, 0);
  assign pre_pick  = pick(bus.req, owner_q, 1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    slot_d  = slot_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (idle_pick[PW]) begin
          state_d = GRANT;
          owner_d = idle_pick[PW-1:0];
          rr_d    = wrap_inc(idle_pick[PW-1:0]);
          slot_d  = '0;
          busy_d  = 1'b1;
          gnt_d   = '0;
          gnt_d[idle_pick[PW-1:0]] = 1'b1;
        end
      end
      default: begin
        // A dropped request wins over slot expiry in the same cycle.
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          slot_d  = '0;
          busy_d  = 1'b0;
          gnt_d   = '0;
        end else if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (pre_pick[PW]) begin
            owner_d = pre_pick[PW-1:0];
            rr_d    = wrap_inc(pre_pick[PW-1:0]);
            gnt_d   = '0;
            gnt_d[pre_pick[PW-1:0]] = 1'b1;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + RW'(1);
    scan_d    = scan_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      scan_d    = scan_q + 2'd1;
    end
    // Display follows next-state busy/owner so it blanks or lights together with gnt.
    an_d  = busy_d ? ~(4'b0001 << scan_q) : 4'hF;
    seg_d = busy_d ? frame_byte[owner_d][scan_q] : 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      slot_q    <= '0;
      refresh_q <= '0;
      scan_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      slot_q    <= slot_d;
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter: a 4-requester instance for scan,
// pre-emption, release and reset, plus a 3-requester instance for pointer wrap.
module tb_sseg_display_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_display_arbiter_if #(.NUM_REQ(4)) bus4 ();
  sseg_display_arbiter_if #(.NUM_REQ(3)) bus3 ();

  sseg_display_arbiter #(.NUM_REQ(4), .REFRESH_CYCLES(4), .SLOT_CYCLES(16)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  sseg_display_arbiter #(.NUM_REQ(3), .REFRESH_CYCLES(4), .SLOT_CYCLES(16)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  logic [31:0] fr [4];
  assign bus4.frame = {fr[3], fr[2], fr[1], fr[0]};
  assign bus3.frame = {fr[2], fr[1], fr[0]};

  // Edges since reset release: digit index shown after edge k is ((k-1)/4)%4.
  int edges;
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  typedef struct {
    logic [3:0] req;
    int         cycles;
    logic [3:0] gnt;
    logic       busy;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("gnt4_onehot0", 32'($onehot0(bus4.gnt)), 32'd1);
    chk("gnt3_onehot0", 32'($onehot0(bus3.gnt)), 32'd1);
  endtask

  function automatic int gnt_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk_disp(input string name, input logic busy, input int owner);
    int         d;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    if (!busy) begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      d       = ((edges - 1) / 4) % 4;
      exp_an  = ~(4'b0001 << d);
      exp_seg = fr[owner][8*d +: 8];
    end
    chk({name, "_an"}, 32'(bus4.an), 32'(exp_an));
    chk({name, "_seg"}, 32'(bus4.seg), 32'(exp_seg));
  endtask

  initial begin
    logic [3:0] seq [4];
    logic [3:0] eg;
    logic [2:0] e3;

    fr[0] = 32'hC0F9A4B0;
    fr[1] = 32'h92998882;
    fr[2] = 32'h11223344;
    fr[3] = 32'h55667788;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000; seq[3] = 4'b0001;

    //            req      cyc  gnt      busy
    vecs[0]  = '{4'b0100, 1,  4'b0000, 1'b0};  // owner 0 drops at slot 5
    vecs[1]  = '{4'b0100, 1,  4'b0100, 1'b1};
    vecs[2]  = '{4'b0000, 1,  4'b0000, 1'b0};
    vecs[3]  = '{4'b0010, 1,  4'b0010, 1'b1};  // pointer 3 wraps to 1
    vecs[4]  = '{4'b1010, 15, 4'b0010, 1'b1};  // waiter does not disturb slot
    vecs[5]  = '{4'b1000, 1,  4'b0000, 1'b0};  // release beats expiry at 15
    vecs[6]  = '{4'b1000, 1,  4'b1000, 1'b1};
    vecs[7]  = '{4'b0000, 1,  4'b0000, 1'b0};
    vecs[8]  = '{4'b0100, 1,  4'b0100, 1'b1};  // one-cycle request pulse
    vecs[9]  = '{4'b0000, 1,  4'b0000, 1'b0};
    vecs[10] = '{4'b0000, 1,  4'b0000, 1'b0};

    reset     = 1'b1;
    bus4.req  = '0;
    bus3.req  = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(bus4.gnt), 32'd0);
    chk("reset_busy", 32'(bus4.busy), 32'd0);
    chk_disp("reset", 1'b0, 0);

    // Pre-emption rotation 0 -> 1 -> 3 -> 0, 16 cycles each, no gap.
    bus4.req = 4'b1011;
    reset    = 1'b0;
    for (int k = 1; k <= 54; k++) begin
      step();
      eg = seq[(k - 1) / 16];
      chk("rot_gnt", 32'(bus4.gnt), 32'(eg));
      chk("rot_busy", 32'(bus4.busy), 32'd1);
      chk_disp("rot", 1'b1, gnt_idx(eg));
    end
    $display("rotation: %0d cycles, gnt=%b", 54, bus4.gnt);

    for (int v = 0; v < 11; v++) begin
      bus4.req = vecs[v].req;
      repeat (vecs[v].cycles) step();
      $display("vec %0d: req=%b gnt=%b busy=%b an=%b seg=%h",
               v, vecs[v].req, bus4.gnt, bus4.busy, bus4.an, bus4.seg);
      chk("vec_gnt", 32'(bus4.gnt), 32'(vecs[v].gnt));
      chk("vec_busy", 32'(bus4.busy), 32'(vecs[v].busy));
      chk_disp("vec", vecs[v].busy, gnt_idx(vecs[v].gnt));
    end

    // Single owner: grant next cycle, digit scan, kept past slot expiry.
    bus4.req = 4'b0001;
    step();
    chk("single_gnt", 32'(bus4.gnt), 32'h1);
    chk_disp("single", 1'b1, 0);
    for (int k = 0; k < 24; k++) begin
      step();
      chk("scan_gnt", 32'(bus4.gnt), 32'h1);
      chk("scan_busy", 32'(bus4.busy), 32'd1);
      chk_disp("scan", 1'b1, 0);
    end
    $display("scan: gnt=%b after 25 cycles", bus4.gnt);

    // Asynchronous reset mid-grant, then 40 idle cycles.
    #2 reset = 1'b1;
    bus4.req = '0;
    #1;
    chk("areset_gnt", 32'(bus4.gnt), 32'd0);
    chk("areset_busy", 32'(bus4.busy), 32'd0);
    chk_disp("areset", 1'b0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("idle_gnt", 32'(bus4.gnt), 32'd0);
      chk("idle_busy", 32'(bus4.busy), 32'd0);
      chk_disp("idle", 1'b0, 0);
    end
    $display("idle: 40 cycles, gnt=%b an=%b seg=%h", bus4.gnt, bus4.an, bus4.seg);

    // Three requesters, all held from reset: order 0,1,2,0.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      step();
      e3 = 3'b001 << (((k - 1) / 16) % 3);
      chk("n3_gnt", 32'(bus3.gnt), 32'(e3));
      chk("n3_busy", 32'(bus3.busy), 32'd1);
    end
    $display("n3: 52 cycles, gnt=%b", bus3.gnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
